// File: rtl/sample_capture.sv
// sample_capture: consumer end of the sampling_control handshake.
// Captures the DDS sample stream into an on-chip buffer with optional
// decimation, reports Ready/Busy back to the controller, and offers a
// synchronous random-access readback port.
module sample_capture #(
  parameter int DATA_WIDTH  = 12,
  parameter int ADDR_WIDTH  = 8,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   Fg_CLK,
  input  logic                   RESETn,
  input  logic                   Enable,
  input  logic                   Mode,
  input  logic [DATA_WIDTH-1:0]  Sample_i,
  input  logic                   Sample_valid_i,
  input  logic [DECIM_WIDTH-1:0] Decim_i,
  input  logic [ADDR_WIDTH-1:0]  Rd_addr_i,
  output logic [DATA_WIDTH-1:0]  Rd_data_o,
  output logic                   Ready,
  output logic                   Busy_o,
  output logic [ADDR_WIDTH-1:0]  Wr_ptr_o,
  output logic [ADDR_WIDTH:0]    Count_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                 r_state;
  logic                   r_mode;
  logic [DECIM_WIDTH-1:0] r_decim;
  logic [DECIM_WIDTH-1:0] r_decim_cnt;
  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];

  // A valid sample is kept only when the decimation phase has reached the
  // setting latched at capture start; live Mode/Decim_i are never used here.
  logic                   w_take;
  logic                   w_wr_en;
  logic [ADDR_WIDTH:0]    w_count_inc;
  logic                   w_fill_done;
  logic                   w_exit;

  assign w_take      = Sample_valid_i && (r_decim_cnt == r_decim);
  assign w_wr_en     = (r_state == ST_CAPTURE) && w_take;
  assign w_count_inc = (Count_o == FULL_COUNT) ? Count_o : Count_o + 1'b1;
  assign w_fill_done = !r_mode && w_wr_en && (w_count_inc == FULL_COUNT);
  assign w_exit      = !Enable || w_fill_done;

  // Capture control FSM; every handshake and status output is registered here.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_decim     <= '0;
      r_decim_cnt <= '0;
      Ready       <= 1'b0;
      Busy_o      <= 1'b0;
      Wr_ptr_o    <= '0;
      Count_o     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Enable) begin
            r_mode      <= Mode;
            r_decim     <= Decim_i;
            r_decim_cnt <= '0;
            Wr_ptr_o    <= '0;
            Count_o     <= '0;
            Ready       <= 1'b0;
            Busy_o      <= 1'b1;
            r_state     <= ST_CAPTURE;
          end else begin
            Ready  <= 1'b1;
            Busy_o <= 1'b0;
          end
        end

        ST_CAPTURE: begin
          if (Sample_valid_i) begin
            if (w_take) begin
              Wr_ptr_o    <= Wr_ptr_o + 1'b1;
              Count_o     <= w_count_inc;
              r_decim_cnt <= '0;
            end else begin
              r_decim_cnt <= r_decim_cnt + 1'b1;
            end
          end
          if (w_exit) begin
            Ready   <= 1'b1;
            Busy_o  <= 1'b0;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          Ready  <= 1'b1;
          Busy_o <= 1'b0;
          if (!Enable) begin
            r_state <= ST_IDLE;
          end
        end

        default: begin
          Ready   <= 1'b0;
          Busy_o  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Sample buffer write port; contents deliberately survive reset.
  always_ff @(posedge Fg_CLK) begin
    if (w_wr_en) begin
      r_mem[Wr_ptr_o] <= Sample_i;
    end
  end

  // Registered readback; a same-edge write to this address returns old data.
  always_ff @(posedge Fg_CLK or negedge RESETn) begin
    if (!RESETn) begin
      Rd_data_o <= '0;
    end else begin
      Rd_data_o <= r_mem[Rd_addr_i];
    end
  end

endmodule

// File: tb/tb_sample_capture.sv
// tb_sample_capture: table-driven, hand-sequenced and randomized checks of
// sample_capture against a behavioural model of the capture rules.
module tb_sample_capture;

  localparam int DW    = 12;
  localparam int AW    = 4;
  localparam int DCW   = 8;
  localparam int DEPTH = 1 << AW;

  logic           Fg_CLK = 1'b0;
  logic           RESETn = 1'b0;
  logic           Enable = 1'b0;
  logic           Mode = 1'b0;
  logic [DW-1:0]  Sample_i = '0;
  logic           Sample_valid_i = 1'b0;
  logic [DCW-1:0] Decim_i = '0;
  logic [AW-1:0]  Rd_addr_i = '0;
  logic [DW-1:0]  Rd_data_o;
  logic           Ready;
  logic           Busy_o;
  logic [AW-1:0]  Wr_ptr_o;
  logic [AW:0]    Count_o;

  int testsRun = 0;
  int testsFailed = 0;

  // Behavioural model: capture outcome expressed as a running count of
  // writes and of valid samples seen since the capture began.
  int            mPhase;
  bit            mReady;
  bit            mBusy;
  int            mWrites;
  int            mSeen;
  bit            mMode;
  int            mDecim;
  logic [DW-1:0] mMem [DEPTH];
  bit            mKnown [DEPTH];
  logic [DW-1:0] mRdExp;
  bit            mRdKnown;

  typedef struct {
    bit            en;
    bit            valid;
    logic [DW-1:0] sample;
    logic [AW-1:0] rdAddr;
    bit            expReady;
    bit            expBusy;
    logic [AW:0]   expCount;
    logic [AW-1:0] expWr;
    bit            chkRd;
    logic [DW-1:0] expRd;
  } vec_t;

  vec_t vecs [37];

  always #5 Fg_CLK = ~Fg_CLK;

  sample_capture #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DECIM_WIDTH(DCW)
  ) dut (
    .Fg_CLK        (Fg_CLK),
    .RESETn        (RESETn),
    .Enable        (Enable),
    .Mode          (Mode),
    .Sample_i      (Sample_i),
    .Sample_valid_i(Sample_valid_i),
    .Decim_i       (Decim_i),
    .Rd_addr_i     (Rd_addr_i),
    .Rd_data_o     (Rd_data_o),
    .Ready         (Ready),
    .Busy_o        (Busy_o),
    .Wr_ptr_o      (Wr_ptr_o),
    .Count_o       (Count_o)
  );

  task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mPhase   = 0;
    mReady   = 1'b0;
    mBusy    = 1'b0;
    mWrites  = 0;
    mSeen    = 0;
    mRdExp   = '0;
    mRdKnown = 1'b1;
    for (int i = 0; i < DEPTH; i++) mKnown[i] = 1'b0;
  endtask

  task automatic modelEdge(input bit en, input bit mode, input bit valid,
                           input logic [DW-1:0] s, input logic [DCW-1:0] d,
                           input logic [AW-1:0] ra);
    mRdKnown = mKnown[ra];
    mRdExp   = mMem[ra];
    case (mPhase)
      0: begin
        if (en) begin
          mPhase  = 1;
          mMode   = mode;
          mDecim  = int'(d);
          mWrites = 0;
          mSeen   = 0;
          mReady  = 1'b0;
          mBusy   = 1'b1;
        end else begin
          mReady = 1'b1;
          mBusy  = 1'b0;
        end
      end
      1: begin
        if (valid) begin
          if (mSeen % (mDecim + 1) == mDecim) begin
            mMem[mWrites % DEPTH]   = s;
            mKnown[mWrites % DEPTH] = 1'b1;
            mWrites++;
          end
          mSeen++;
        end
        if (!en || (!mMode && mWrites >= DEPTH)) begin
          mPhase = 2;
          mReady = 1'b1;
          mBusy  = 1'b0;
        end
      end
      default: begin
        mReady = 1'b1;
        mBusy  = 1'b0;
        if (!en) mPhase = 0;
      end
    endcase
  endtask

  function automatic logic [31:0] modelStatus();
    logic [AW-1:0] wr;
    logic [AW:0]   cnt;
    wr  = AW'(mWrites % DEPTH);
    cnt = (AW + 1)'((mWrites > DEPTH) ? DEPTH : mWrites);
    return 32'({mReady, mBusy, wr, cnt});
  endfunction

  task automatic checkOutput(input string tag);
    expectEq({tag, ".status"}, 32'({Ready, Busy_o, Wr_ptr_o, Count_o}), modelStatus());
    if (mRdKnown) expectEq({tag, ".rd"}, 32'(Rd_data_o), 32'(mRdExp));
  endtask

  task automatic applyStimulus(input bit en, input bit mode, input bit valid,
                               input logic [DW-1:0] s, input logic [DCW-1:0] d,
                               input logic [AW-1:0] ra, input string tag);
    @(negedge Fg_CLK);
    Enable         = en;
    Mode           = mode;
    Sample_valid_i = valid;
    Sample_i       = s;
    Decim_i        = d;
    Rd_addr_i      = ra;
    @(posedge Fg_CLK);
    modelEdge(en, mode, valid, s, d, ra);
    #1;
    checkOutput(tag);
  endtask

  task automatic doReset();
    @(negedge Fg_CLK);
    RESETn         = 1'b0;
    Enable         = 1'b0;
    Sample_valid_i = 1'b0;
    #1;
    modelReset();
    checkOutput("reset.hold");
    repeat (2) @(posedge Fg_CLK);
    #1;
    checkOutput("reset.hold2");
    @(negedge Fg_CLK);
    RESETn = 1'b1;
  endtask

  // Called just after a checked edge: asserts reset between edges.
  task automatic midReset();
    #2;
    RESETn = 1'b0;
    #1;
    modelReset();
    checkOutput("midreset");
    expectEq("midreset.busy", 32'(Busy_o), 32'd0);
    @(negedge Fg_CLK);
    Enable = 1'b0;
    RESETn = 1'b1;
  endtask

  initial begin
    bit en;
    vecs[0] = '{1'b1, 1'b0, DW'(0), AW'(0), 1'b0, 1'b1, (AW + 1)'(0), AW'(0), 1'b0, DW'(0)};
    for (int j = 0; j < 20; j++) begin
      vecs[j + 1] = '{1'b1, 1'b1, DW'(j), AW'(0), (j >= 15), (j < 15),
                      (AW + 1)'((j >= 15) ? 16 : j + 1), AW'((j >= 15) ? 0 : j + 1),
                      1'b0, DW'(0)};
    end
    for (int a = 0; a < 16; a++) begin
      vecs[21 + a] = '{1'b1, 1'b0, DW'(0), AW'(a), 1'b1, 1'b0, (AW + 1)'(16), AW'(0),
                       1'b1, DW'(a)};
    end

    // Reset and release.
    doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "reset.release");
    expectEq("reset.ready_after_release", 32'(Ready), 32'd1);

    // Single-shot fill, held Enable, full readback.
    for (int i = 0; i < 37; i++) begin
      applyStimulus(vecs[i].en, 1'b0, vecs[i].valid, vecs[i].sample, '0, vecs[i].rdAddr, "tbl");
      expectEq($sformatf("tbl[%0d].status", i), 32'({Ready, Busy_o, Wr_ptr_o, Count_o}),
               32'({vecs[i].expReady, vecs[i].expBusy, vecs[i].expWr, vecs[i].expCount}));
      if (vecs[i].chkRd)
        expectEq($sformatf("tbl[%0d].rd", i), 32'(Rd_data_o), 32'(vecs[i].expRd));
    end

    // Decimation by 3 with a valid gap; Mode/Decim_i change mid-capture.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "decim.idle");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, 8'd2, '0, "decim.start");
    for (int k = 0; k < 48; k++) begin
      if (k == 20) begin
        for (int g = 0; g < 3; g++)
          applyStimulus(1'b1, 1'b1, 1'b0, DW'(999), 8'd0, '0, "decim.gap");
      end
      applyStimulus(1'b1, (k >= 10), 1'b1, DW'(k), (k >= 10) ? 8'd0 : 8'd2, '0, "decim.run");
    end
    expectEq("decim.count", 32'(Count_o), 32'd16);
    expectEq("decim.ready", 32'(Ready), 32'd1);
    for (int a = 0; a < 16; a += 5) begin
      applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, AW'(a), "decim.read");
      expectEq($sformatf("decim.rd[%0d]", a), 32'(Rd_data_o), 32'(3 * a + 2));
    end

    // Ring capture of 40 samples, stopped by Enable low.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "ring.idle");
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, '0, "ring.start");
    for (int k = 0; k < 40; k++)
      applyStimulus(1'b1, 1'b1, 1'b1, DW'(k), '0, '0, "ring.run");
    applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, "ring.stop");
    expectEq("ring.count", 32'(Count_o), 32'd16);
    expectEq("ring.wrptr", 32'(Wr_ptr_o), 32'd8);
    expectEq("ring.busy", 32'(Busy_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, AW'(8), "ring.read8");
    expectEq("ring.oldest", 32'(Rd_data_o), 32'd24);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, AW'(7), "ring.read7");
    expectEq("ring.newest", 32'(Rd_data_o), 32'd39);

    // Abort after 5 writes, held-Enable in DONE, then retrigger.
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, "abort.start");
    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, 1'b0, 1'b1, DW'(100 + k), '0, '0, "abort.run");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "abort.stop");
    expectEq("abort.count", 32'(Count_o), 32'd5);
    expectEq("abort.ready", 32'(Ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b1, '0, '0, '0, "abort.done_hold");
    expectEq("abort.no_retrigger", 32'(Busy_o), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "abort.to_idle");
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, "abort.retrigger");
    expectEq("abort.restart_count", 32'(Count_o), 32'd0);
    expectEq("abort.restart_busy", 32'(Busy_o), 32'd1);

    // Reset in the middle of a capture.
    for (int k = 0; k < 3; k++)
      applyStimulus(1'b1, 1'b0, 1'b1, DW'(200 + k), '0, '0, "midrst.run");
    midReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, "midrst.release");

    // Randomized traffic against the model.
    en = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      applyStimulus(en, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                    DW'($urandom), DCW'($urandom_range(0, 3)), AW'($urandom), "rand");
      if ($urandom_range(0, 299) == 0) begin
        midReset();
        en = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/sample_capture.md
Name: sample_capture

Overview:
Consumer end of the sampling_control handshake. It receives Enable/Mode from sampling_control and captures the DDS output sample stream into an on-chip buffer, with optional decimation. It returns Ready to sampling_control when the buffer is idle or holds a finished capture. The captured buffer is read back through a synchronous random-access port for display or export.

Parameters:
DATA_WIDTH, 12, width of one DDS sample
ADDR_WIDTH, 8, buffer address width; DEPTH = 2^ADDR_WIDTH samples
DECIM_WIDTH, 8, width of the decimation setting

Ports:
Fg_CLK  in  1  system clock; all logic on rising edge
RESETn  in  1  asynchronous active-low reset
Enable  in  1  capture request level from sampling_control
Mode  in  1  0 = single-shot (stop when full), 1 = continuous ring (stop on Enable low)
Sample_i  in  DATA_WIDTH  DDS sample
Sample_valid_i  in  1  Sample_i valid this cycle
Decim_i  in  DECIM_WIDTH  store 1 of every Decim_i+1 valid samples
Rd_addr_i  in  ADDR_WIDTH  readback address
Rd_data_o  out  DATA_WIDTH  readback data, 1-cycle latency
Ready  out  1  to sampling_control: idle or capture complete
Busy_o  out  1  capture in progress
Wr_ptr_o  out  ADDR_WIDTH  next write address
Count_o  out  ADDR_WIDTH+1  samples stored, saturates at DEPTH

Behaviour:
- Reset (RESETn low, asynchronous):
  - State = IDLE.
  - Ready=0, Busy_o=0, Wr_ptr_o=0, Count_o=0, Rd_data_o=0, decimation counter=0.
  - Buffer contents are not cleared.
- After reset release, Ready goes to 1 on the first rising edge.
- FSM states: IDLE, CAPTURE, DONE. All outputs are registered.
  - Ready = 1 in IDLE and DONE, 0 in CAPTURE.
  - Busy_o = 1 only in CAPTURE.
- IDLE:
  - On an edge where Enable=1: latch Mode and Decim_i into internal copies.
  - Clear Wr_ptr_o, Count_o and the decimation counter; go to CAPTURE.
  - Ready is 0 and Busy_o is 1 from the following cycle.
- CAPTURE, on each edge with Sample_valid_i=1:
  - If decim_cnt == latched Decim: write Sample_i at Wr_ptr_o, Wr_ptr_o += 1 (wraps mod DEPTH), Count_o += 1 saturating at DEPTH, decim_cnt = 0.
  - Otherwise decim_cnt += 1.
  - Cycles with Sample_valid_i=0 change nothing.
- Mode 0 exits:
  - CAPTURE → DONE on the edge that performs the DEPTH-th write.
  - Enable=0 during CAPTURE aborts to DONE, keeping the partial Count_o.
- Mode 1 exits:
  - Writes wrap and overwrite the oldest samples.
  - CAPTURE → DONE on the first edge where Enable=0.
- Simultaneous events:
  - A qualifying write on the same edge as the exit condition is still performed; the state then moves to DONE.
  - Changes to Mode or Decim_i during CAPTURE are ignored.
- DONE:
  - Holds Count_o and Wr_ptr_o.
  - Stays in DONE while Enable=1, so a held Enable does not retrigger.
  - Enable=0 → IDLE.
  - A new capture requires Enable low then high again.
- Readout:
  - Rd_data_o = mem[Rd_addr_i] registered, one cycle after the address.
  - Reads are legal in any state.
  - A read and write to the same address on the same edge returns the old data.
  - Mode 1 with Count_o = DEPTH: oldest sample is at Wr_ptr_o, newest at Wr_ptr_o−1.
  - Otherwise valid data is at addresses 0..Count_o−1.
- Reset mid-capture: aborts immediately to IDLE with the reset values above. Stored samples are unspecified.

Test Plan:
1. Reset: hold RESETn=0 → Ready=0, Busy_o=0, Count_o=0, Wr_ptr_o=0. Release → Ready=1 on the next edge.
2. Single-shot, ADDR_WIDTH=4, Decim_i=0, Enable=1, Sample_i=0..19 valid every cycle → Ready=0 one cycle after Enable sampled. Then Count_o=16, DONE, Ready=1 after the 16th write. Reads of addr 0..15 return 0..15; samples 16..19 are not stored.
3. Decimation: Decim_i=2, Sample_i=0..47 valid every cycle, with Sample_valid_i low for 3 cycles mid-stream → stored 2,5,8,…,47 (16 samples); the gap does not disturb the decimation phase.
4. Ring: Mode=1, DEPTH=16, Decim_i=0, 40 samples 0..39, then Enable=0 → Count_o=16, Wr_ptr_o=8, addr 8 = 24, addr 7 = 39, DONE.
5. Abort and retrigger: Mode=0, Enable drops after 5 writes → DONE, Count_o=5, Ready=1. Keep Enable=1 after a full capture → no new capture. Toggle Enable 0→1 → Count_o restarts at 0.
6. Reset mid-capture, and Mode/Decim_i toggled during CAPTURE → reset gives instant IDLE with Ready=0. The mid-capture toggles do not alter write pattern or exit condition.
